fetch_pipeline_ctrl: RTL and testbench

- Consumer side of the hazard/flush control interface: owns the PC register, the IF/ID pipeline register and the valid/control half of the ID/EX register.
- Applies the stall, bubble and flush requests driven by the hazard detection logic, and applies branch/jump redirects from MEM.
- Keeps saturating stall/flush performance counters.
- Sits between instruction memory and the decode stage of the 5-stage RV32I core.

---
 rtl/fetch_pipeline_ctrl_if.sv | 38 +++
 rtl/fetch_pipeline_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_pipeline_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pipeline_ctrl_if.sv
// Hazard/flush control bus between the hazard unit, instruction memory,
// decoder and the fetch pipeline controller.
interface fetch_pipeline_ctrl_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic              pc_write_id;
  logic              hazard_mux;
  logic              flush;
  logic              flush_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_target;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_rdata;
  logic [CTRL_W-1:0] id_ctrl_in;
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              id_ex_valid;
  logic              misaligned;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport slave (
    input  pc_write_id, hazard_mux, flush, flush_pc,
    input  redirect_valid, redirect_target, imem_rdata, id_ctrl_in,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid,
    output id_ex_ctrl, id_ex_valid, misaligned, stall_count, flush_count
  );

  modport master (
    output pc_write_id, hazard_mux, flush, flush_pc,
    output redirect_valid, redirect_target, imem_rdata, id_ctrl_in,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
    input  id_ex_ctrl, id_ex_valid, misaligned, stall_count, flush_count
  );
endinterface

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch-side pipeline control: PC, IF/ID register, ID/EX valid/control,
// applying stall/bubble/flush/redirect and keeping saturating perf counters.
module fetch_pipeline_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 16,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                   clk,
  input logic                   rst,
  fetch_pipeline_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              kill_s;
  logic [31:0]       pc_q,          pc_d;
  logic [31:0]       if_id_pc_q,    if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] id_ex_ctrl_q,  id_ex_ctrl_d;
  logic              id_ex_valid_q, id_ex_valid_d;
  logic              misaligned_q,  misaligned_d;
  logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;

  assign kill_s = bus.redirect_valid | bus.flush;

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    // Redirect beats stall and flush_pc; low target bits are dropped, not trapped.
    if (bus.redirect_valid) begin
      pc_d         = {bus.redirect_target[31:2], 2'b00};
      misaligned_d = misaligned_q | (bus.redirect_target[1:0] != 2'b00);
    end else if (!bus.pc_write_id) begin
      pc_d = pc_q;
    end else if (bus.flush_pc) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (kill_s) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (!bus.pc_write_id) begin
      if_id_valid_d = if_id_valid_q;
    end else if (bus.flush_pc) begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = bus.imem_rdata;
      if_id_valid_d = 1'b1;
    end
  end

  always_comb begin
    id_ex_ctrl_d  = id_ex_ctrl_q;
    id_ex_valid_d = id_ex_valid_q;
    // A stall without hazard_mux still lets ID/EX advance.
    if (kill_s || bus.hazard_mux) begin
      id_ex_ctrl_d  = {CTRL_W{1'b0}};
      id_ex_valid_d = 1'b0;
    end else begin
      id_ex_ctrl_d  = bus.id_ctrl_in;
      id_ex_valid_d = if_id_valid_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.pc_write_id && !kill_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (kill_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      id_ex_ctrl_q  <= {CTRL_W{1'b0}};
      id_ex_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      stall_cnt_q   <= {CNT_W{1'b0}};
      flush_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      id_ex_ctrl_q  <= id_ex_ctrl_d;
      id_ex_valid_q <= id_ex_valid_d;
      misaligned_q  <= misaligned_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.id_ex_ctrl  = id_ex_ctrl_q;
  assign bus.id_ex_valid = id_ex_valid_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Directed bench for fetch_pipeline_ctrl with a 4-bit counter instance so
// stall saturation is reachable quickly.
module tb_fetch_pipeline_ctrl;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_pipeline_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  fetch_pipeline_ctrl #(
    .RESET_PC (32'h0000_0000),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0000) return 32'h0050_0093;
    return {addr[23:0], 8'h13};
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},     bus.imem_addr, 32'h0000_0000);
    chk({tag, "_ifpc"},   bus.if_id_pc, 32'h0000_0000);
    chk({tag, "_ifins"},  bus.if_id_instr, 32'h0000_0013);
    chk({tag, "_ifv"},    {31'd0, bus.if_id_valid}, 32'd0);
    chk({tag, "_exctl"},  {16'd0, bus.id_ex_ctrl}, 32'd0);
    chk({tag, "_exv"},    {31'd0, bus.id_ex_valid}, 32'd0);
    chk({tag, "_mis"},    {31'd0, bus.misaligned}, 32'd0);
    chk({tag, "_scnt"},   {28'd0, bus.stall_count}, 32'd0);
    chk({tag, "_fcnt"},   {28'd0, bus.flush_count}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.pc_write_id     = 1'b1;
    bus.hazard_mux      = 1'b0;
    bus.flush           = 1'b0;
    bus.flush_pc        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0000_0000;
    bus.id_ctrl_in      = 16'h1234;
    #2;
    chk_reset_state("rst");
    #10 rst = 1'b0;

    // first fetch
    step();
    chk("f1_ifpc",  bus.if_id_pc, 32'h0000_0000);
    chk("f1_ifins", bus.if_id_instr, 32'h0050_0093);
    chk("f1_ifv",   {31'd0, bus.if_id_valid}, 32'd1);
    chk("f1_pc",    bus.imem_addr, 32'h0000_0004);
    chk("f1_scnt",  {28'd0, bus.stall_count}, 32'd0);
    step();
    chk("f2_pc",    bus.imem_addr, 32'h0000_0008);
    chk("f2_exv",   {31'd0, bus.id_ex_valid}, 32'd1);
    chk("f2_exctl", {16'd0, bus.id_ex_ctrl}, 32'h0000_1234);

    // load-use stall with bubble at pc 0x8
    bus.pc_write_id = 1'b0;
    bus.hazard_mux  = 1'b1;
    step();
    chk("st_pc",    bus.imem_addr, 32'h0000_0008);
    chk("st_ifpc",  bus.if_id_pc, 32'h0000_0004);
    chk("st_ifins", bus.if_id_instr, imem_word(32'h0000_0004));
    chk("st_exv",   {31'd0, bus.id_ex_valid}, 32'd0);
    chk("st_exctl", {16'd0, bus.id_ex_ctrl}, 32'd0);
    chk("st_scnt",  {28'd0, bus.stall_count}, 32'd1);
    bus.pc_write_id = 1'b1;
    bus.hazard_mux  = 1'b0;
    step();
    chk("st2_pc",   bus.imem_addr, 32'h0000_000C);
    chk("st2_ifpc", bus.if_id_pc, 32'h0000_0008);
    chk("st2_exv",  {31'd0, bus.id_ex_valid}, 32'd1);
    chk("st2_scnt", {28'd0, bus.stall_count}, 32'd1);

    // redirect during stall: redirect wins
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0100;
    bus.pc_write_id     = 1'b0;
    step();
    chk("rd_pc",    bus.imem_addr, 32'h0000_0100);
    chk("rd_ifins", bus.if_id_instr, 32'h0000_0013);
    chk("rd_ifv",   {31'd0, bus.if_id_valid}, 32'd0);
    chk("rd_ifpc",  bus.if_id_pc, 32'h0000_000C);
    chk("rd_exv",   {31'd0, bus.id_ex_valid}, 32'd0);
    chk("rd_fcnt",  {28'd0, bus.flush_count}, 32'd1);
    chk("rd_scnt",  {28'd0, bus.stall_count}, 32'd1);
    bus.redirect_valid = 1'b0;
    bus.pc_write_id    = 1'b1;
    step();
    chk("rd2_ifpc",  bus.if_id_pc, 32'h0000_0100);
    chk("rd2_ifins", bus.if_id_instr, imem_word(32'h0000_0100));
    chk("rd2_ifv",   {31'd0, bus.if_id_valid}, 32'd1);
    chk("rd2_pc",    bus.imem_addr, 32'h0000_0104);

    // flush_pc for two cycles at 0x20
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0020;
    step();
    bus.redirect_valid = 1'b0;
    bus.flush_pc       = 1'b1;
    step();
    chk("fp1_pc",    bus.imem_addr, 32'h0000_0020);
    chk("fp1_ifins", bus.if_id_instr, 32'h0000_0013);
    chk("fp1_ifv",   {31'd0, bus.if_id_valid}, 32'd0);
    step();
    chk("fp2_pc",    bus.imem_addr, 32'h0000_0020);
    chk("fp2_ifv",   {31'd0, bus.if_id_valid}, 32'd0);
    bus.flush_pc = 1'b0;
    step();
    chk("fp3_ifpc",  bus.if_id_pc, 32'h0000_0020);
    chk("fp3_ifins", bus.if_id_instr, imem_word(32'h0000_0020));
    chk("fp3_ifv",   {31'd0, bus.if_id_valid}, 32'd1);
    chk("fp3_pc",    bus.imem_addr, 32'h0000_0024);
    chk("fp3_fcnt",  {28'd0, bus.flush_count}, 32'd2);

    // flush together with flush_pc: PC holds, IF/ID killed
    bus.flush    = 1'b1;
    bus.flush_pc = 1'b1;
    step();
    chk("ff_pc",    bus.imem_addr, 32'h0000_0024);
    chk("ff_ifv",   {31'd0, bus.if_id_valid}, 32'd0);
    chk("ff_ifpc",  bus.if_id_pc, 32'h0000_0024);
    chk("ff_exv",   {31'd0, bus.id_ex_valid}, 32'd0);
    chk("ff_fcnt",  {28'd0, bus.flush_count}, 32'd3);
    bus.flush    = 1'b0;
    bus.flush_pc = 1'b0;

    // misaligned redirect is sticky and still redirects
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0106;
    step();
    chk("ma_pc",  bus.imem_addr, 32'h0000_0104);
    chk("ma_mis", {31'd0, bus.misaligned}, 32'd1);
    bus.redirect_valid = 1'b0;
    step();
    step();
    chk("ma2_pc",  bus.imem_addr, 32'h0000_010C);
    chk("ma2_mis", {31'd0, bus.misaligned}, 32'd1);

    // PC wrap
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wr_pc", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    step();
    chk("wr2_pc",   bus.imem_addr, 32'h0000_0000);
    chk("wr2_ifpc", bus.if_id_pc, 32'hFFFF_FFFC);
    chk("wr2_fcnt", {28'd0, bus.flush_count}, 32'd5);

    // stall counter saturates at 15 (starts from 1)
    bus.pc_write_id = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("sat14_scnt", {28'd0, bus.stall_count}, 32'd14);
    for (int i = 0; i < 7; i++) step();
    chk("sat_scnt", {28'd0, bus.stall_count}, 32'd15);
    chk("sat_pc",   bus.imem_addr, 32'h0000_0000);

    // asynchronous reset mid-stall, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk_reset_state("arst");
    bus.pc_write_id = 1'b1;
    #10 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
